spi_slave: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 41 ++++
 rtl/spi_slave_sync.sv | 58 +++++
 rtl/spi_slave.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI target peripheral.
// Register map, STATUS layout and frame geometry.
package spi_slave_pkg;

    typedef enum logic {
        REG_DATA   = 1'b0,
        REG_STATUS = 1'b1
    } reg_addr_e;

    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_UNDERRUN = 3;
    localparam int ST_ACTIVE   = 4;
    localparam int ST_BUSY     = 5;

    typedef struct packed {
        logic busy;
        logic active;
        logic underrun;
        logic overrun;
        logic tx_full;
        logic rx_valid;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] r;
        r              = '0;
        r[ST_RX_VALID] = s.rx_valid;
        r[ST_TX_FULL]  = s.tx_full;
        r[ST_OVERRUN]  = s.overrun;
        r[ST_UNDERRUN] = s.underrun;
        r[ST_ACTIVE]   = s.active;
        r[ST_BUSY]     = s.busy;
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous SPI pins into clk and flags their edges.
// Chains reset to bus idle levels so reset never fakes an edge.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic ss_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s,
    output logic ss_n_s
);

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [SYNC_STAGES-1:0] ss_q, ss_d;
    logic                   sclk_h_q, sclk_h_d;
    logic                   ss_h_q, ss_h_d;
    logic                   sclk_s;

    always_comb begin
        sclk_d   = {sclk_q[SYNC_STAGES-2:0], sclk};
        mosi_d   = {mosi_q[SYNC_STAGES-2:0], mosi};
        ss_d     = {ss_q[SYNC_STAGES-2:0], ss_n};
        sclk_h_d = sclk_q[SYNC_STAGES-1];
        ss_h_d   = ss_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q   <= '0;
            mosi_q   <= '0;
            ss_q     <= '1;
            sclk_h_q <= 1'b0;
            ss_h_q   <= 1'b1;
        end else begin
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ss_q     <= ss_d;
            sclk_h_q <= sclk_h_d;
            ss_h_q   <= ss_h_d;
        end
    end

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign ss_n_s    = ss_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_h_q;
    assign sclk_fall = ~sclk_s & sclk_h_q;
    assign ss_fall   = ~ss_n_s & ss_h_q;
    assign ss_rise   = ss_n_s & ~ss_h_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI target with one-byte RX/TX holding registers.
// CPU sees DATA and STATUS registers plus a level interrupt.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] TX_IDLE     = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic        address,
    input  logic [31:0] data_in,
    input  logic [3:0]  be,
    output logic [31:0] data_out,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso,
    output logic        miso_oe,
    output logic        irq
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic mosi_s, ss_n_s;

    spi_slave_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .mosi_s   (mosi_s),
        .ss_n_s   (ss_n_s)
    );

    logic [FRAME_BITS-1:0] rx_hold_q, rx_hold_d;
    logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0] tx_hold_q, tx_hold_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_full_q, tx_full_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
    logic                  skip_fall_q, skip_fall_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  irq_q, irq_d;

    reg_addr_e             addr_e;
    logic                  active;
    logic                  data_rd, data_wr, stat_wr;
    logic                  byte_done, tx_load;
    logic [FRAME_BITS-1:0] new_byte;
    status_t               st;
    logic                  unused_bits;

    assign addr_e      = reg_addr_e'(address);
    assign active      = ~ss_n_s;
    assign unused_bits = ^{data_in[31:8], be[3:1]};

    always_comb begin
        data_rd   = read & (addr_e == REG_DATA);
        data_wr   = write & be[0] & (addr_e == REG_DATA);
        stat_wr   = write & be[0] & (addr_e == REG_STATUS);
        byte_done = active & sclk_rise & (bitcnt_q == LAST);
        tx_load   = ss_fall | byte_done;
        new_byte  = {rx_shift_q[FRAME_BITS-2:0], mosi_s};

        rx_hold_d   = rx_hold_q;
        rx_shift_d  = rx_shift_q;
        tx_hold_d   = tx_hold_q;
        tx_shift_d  = tx_shift_q;
        bitcnt_d    = bitcnt_q;
        rx_valid_d  = rx_valid_q;
        tx_full_d   = tx_full_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        skip_fall_d = skip_fall_q;

        // CPU clears go first so any same-cycle hardware set wins.
        if (data_rd) rx_valid_d = 1'b0;
        if (stat_wr && data_in[ST_OVERRUN]) overrun_d = 1'b0;
        if (stat_wr && data_in[ST_UNDERRUN]) underrun_d = 1'b0;

        if (ss_fall || ss_rise) begin
            bitcnt_d    = '0;
            skip_fall_d = 1'b0;
        end

        if (active && sclk_rise) begin
            rx_shift_d = new_byte;
            bitcnt_d   = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == LAST) begin
                skip_fall_d = 1'b1;
                if (!rx_valid_q || data_rd) begin
                    rx_hold_d  = new_byte;
                    rx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end

        // The fall after a completed byte must not shift out the fresh MSB.
        if (active && sclk_fall) begin
            if (skip_fall_q) skip_fall_d = 1'b0;
            else tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b1};
        end

        if (tx_load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_hold_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = TX_IDLE;
                underrun_d = 1'b1;
            end
        end

        if (data_wr) begin
            tx_hold_d = data_in[FRAME_BITS-1:0];
            tx_full_d = 1'b1;
        end

        miso_oe_d = active;
        irq_d     = rx_valid_q | overrun_q | (active & ~tx_full_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_hold_q   <= '0;
            rx_shift_q  <= '0;
            tx_hold_q   <= '0;
            tx_shift_q  <= TX_IDLE;
            bitcnt_q    <= '0;
            rx_valid_q  <= 1'b0;
            tx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            skip_fall_q <= 1'b0;
            miso_oe_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rx_hold_q   <= rx_hold_d;
            rx_shift_q  <= rx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_shift_q  <= tx_shift_d;
            bitcnt_q    <= bitcnt_d;
            rx_valid_q  <= rx_valid_d;
            tx_full_q   <= tx_full_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            skip_fall_q <= skip_fall_d;
            miso_oe_q   <= miso_oe_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        st.rx_valid = rx_valid_q;
        st.tx_full  = tx_full_q;
        st.overrun  = overrun_q;
        st.underrun = underrun_q;
        st.active   = active;
        st.busy     = active & (bitcnt_q != '0);
    end

    always_comb begin
        data_out = '0;
        unique case (addr_e)
            REG_DATA:   data_out = {{(32-FRAME_BITS){1'b0}}, rx_hold_q};
            REG_STATUS: data_out = pack_status(st);
        endcase
    end

    assign miso    = tx_shift_q[FRAME_BITS-1];
    assign miso_oe = miso_oe_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboarded bench for spi_slave: an SPI controller model, CPU bus
// tasks and a transaction-level reference of the holding registers.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        address = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  be = '0;
    logic [31:0] data_out;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic        miso, miso_oe, irq;

    spi_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .read    (read),
        .write   (write),
        .address (address),
        .data_in (data_in),
        .be      (be),
        .data_out(data_out),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso),
        .miso_oe (miso_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t exp_q[$];
    sb_t obs_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  stim_done = 0;

    // Reference state: what the CPU and controller should see.
    logic [7:0] m_rx_hold = 8'h00;
    bit         m_rx_valid = 0;
    logic [7:0] m_tx_hold = 8'h00;
    bit         m_tx_full = 0;
    bit         m_overrun = 0;
    bit         m_underrun = 0;
    logic [7:0] m_cur_tx = 8'hFF;

    logic [7:0] frame_q[$];

    function automatic logic [31:0] m_status(input bit act, input bit busy);
        logic [31:0] r;
        r = '0;
        r[0] = m_rx_valid;
        r[1] = m_tx_full;
        r[2] = m_overrun;
        r[3] = m_underrun;
        r[4] = act;
        r[5] = busy;
        return r;
    endfunction

    task automatic m_load();
        if (m_tx_full) begin
            m_cur_tx  = m_tx_hold;
            m_tx_full = 0;
        end else begin
            m_cur_tx   = 8'hFF;
            m_underrun = 1;
        end
    endtask

    task automatic m_complete(input logic [7:0] b);
        if (!m_rx_valid) begin
            m_rx_hold  = b;
            m_rx_valid = 1;
        end else begin
            m_overrun = 1;
        end
        m_load();
    endtask

    task automatic push_exp(input string nm, input logic [31:0] v);
        sb_t e;
        e.name = nm;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic push_obs(input string nm, input logic [31:0] v);
        sb_t o;
        o.name = nm;
        o.val  = v;
        obs_q.push_back(o);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin_chk(input string nm, input logic v_exp);
        push_exp(nm, {31'b0, v_exp});
        @(negedge clk);
        unique case (nm)
            "miso":    push_obs(nm, {31'b0, miso});
            "miso_oe": push_obs(nm, {31'b0, miso_oe});
            default:   push_obs(nm, {31'b0, irq});
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input string nm, input logic a, input logic [31:0] v_exp);
        push_exp(nm, v_exp);
        read    = 1'b1;
        address = a;
        @(negedge clk);
        push_obs(nm, data_out);
        @(posedge clk);
        #1;
        read = 1'b0;
        if (a == 1'b0) m_rx_valid = 0;
    endtask

    task automatic rd_data(input string nm);
        bus_rd(nm, 1'b0, {24'h0, m_rx_hold});
    endtask

    task automatic rd_stat(input string nm);
        bus_rd(nm, 1'b1, m_status(0, 0));
    endtask

    task automatic bus_wr(input logic a, input logic [31:0] d, input logic [3:0] b);
        write   = 1'b1;
        address = a;
        data_in = d;
        be      = b;
        @(posedge clk);
        #1;
        write = 1'b0;
        if (b[0]) begin
            if (a == 1'b0) begin
                m_tx_hold = d[7:0];
                m_tx_full = 1;
            end else begin
                if (d[2]) m_overrun = 0;
                if (d[3]) m_underrun = 0;
            end
        end
    endtask

    task automatic irq_chk(input string nm);
        cyc(2);
        pin_chk(nm, m_rx_valid | m_overrun);
    endtask

    // Mode-0 controller, 16-clk sclk period; sends every byte in frame_q.
    task automatic spi_xfer(input bit rd_last);
        logic [7:0] mb, got, want;
        int n;
        n    = frame_q.size();
        ss_n = 1'b0;
        m_load();
        cyc(8);
        pin_chk("miso_oe", 1'b1);
        for (int k = 0; k < n; k++) begin
            mb   = frame_q[k];
            want = m_cur_tx;
            got  = '0;
            for (int i = 7; i >= 0; i--) begin
                mosi = mb[i];
                cyc(8);
                got[i] = miso;
                sclk   = 1'b1;
                if (rd_last && k == n - 1 && i == 0) begin
                    cyc(2);
                    bus_rd("data_rd_on_done", 1'b0, {24'h0, m_rx_hold});
                    cyc(5);
                end else begin
                    cyc(8);
                end
                sclk = 1'b0;
            end
            push_exp("miso_byte", {24'h0, want});
            push_obs("miso_byte", {24'h0, got});
            m_complete(mb);
        end
        frame_q.delete();
        cyc(8);
        ss_n = 1'b1;
        cyc(8);
    endtask

    task automatic spi_partial(input int nbits);
        ss_n = 1'b0;
        m_load();
        cyc(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = 1'($urandom_range(0, 1));
            cyc(8);
            sclk = 1'b1;
            cyc(8);
            sclk = 1'b0;
        end
        cyc(8);
        bus_rd("stat_busy", 1'b1, m_status(1, nbits % 8 != 0));
        ss_n = 1'b1;
        cyc(8);
    endtask

    // Monitor: pairs each observation with the oldest expectation.
    initial begin
        sb_t o, e;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s: got %h with no expected value", o.name, o.val);
                end else begin
                    e = exp_q.pop_front();
                    if (e.val !== o.val) begin
                        failures++;
                        $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: stimulus did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        cyc(4);
        rst_n = 1'b1;
        cyc(2);

        rd_stat("reset_status");
        pin_chk("miso", 1'b1);
        pin_chk("miso_oe", 1'b0);
        pin_chk("irq", 1'b0);

        bus_wr(1'b0, 32'h0000_00A5, 4'h1);
        frame_q.push_back(8'h3C);
        spi_xfer(0);
        rd_stat("stat_rx_valid");
        rd_data("data_3c");
        rd_stat("stat_after_read");

        frame_q.push_back(8'($urandom));
        frame_q.push_back(8'($urandom));
        spi_xfer(0);
        rd_stat("stat_underrun");
        bus_wr(1'b1, 32'h0000_0008, 4'h1);
        rd_stat("stat_underrun_clr");

        rd_data("drain");
        bus_wr(1'b1, 32'h0000_000C, 4'h1);
        frame_q.push_back(8'h11);
        frame_q.push_back(8'h22);
        spi_xfer(0);
        irq_chk("irq_overrun");
        rd_stat("stat_overrun");
        rd_data("data_11");
        bus_wr(1'b1, 32'h0000_0004, 4'h1);
        irq_chk("irq_cleared");

        spi_partial(4);
        rd_stat("stat_after_partial");
        frame_q.push_back(8'h5A);
        spi_xfer(0);
        rd_data("data_5a");
        rd_stat("stat_after_5a");

        bus_wr(1'b1, 32'h0000_000C, 4'h1);
        frame_q.push_back(8'h81);
        spi_xfer(0);
        frame_q.push_back(8'h7E);
        spi_xfer(1);
        rd_stat("stat_rd_on_done");
        rd_data("data_7e");

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 4));
            unique case (op)
                0: bus_wr(1'b0, $urandom, 4'($urandom));
                1: begin
                    for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                        frame_q.push_back(8'($urandom));
                    spi_xfer(0);
                end
                2: rd_data("rand_data");
                3: rd_stat("rand_status");
                default: bus_wr(1'b1, $urandom, 4'($urandom));
            endcase
            irq_chk("rand_irq");
        end

        cyc(4);
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: exp=%0d obs=%0d left want 0",
                     exp_q.size(), obs_q.size());
        end
        stim_done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
